// File: rtl/cppf_qpll_reset_ctrl.sv
// Per-channel QPLL reset sequencer (INIT/RESET/WAIT_LOCK/STABLE/READY/REFCLK_WAIT/FAIL); optional CPPF_QPLL_LOSS_CNT_EN lock-loss counters.
// Latency: async inputs pass 2 sync flops then 1 FSM cycle; all outputs registered. No backpressure.
module cppf_qpll_reset_ctrl #(
  parameter int NUM_QPLL         = 3,
  parameter int INIT_WAIT_CYC    = 20,
  parameter int RESET_PULSE_CYC  = 4,
  parameter int LOCK_TIMEOUT_CYC = 4000,
  parameter int LOCK_STABLE_CYC  = 16,
  parameter int MAX_RETRY        = 3
) (
  input  logic                  sysclk_in_i,
  input  logic                  reset_n,
  input  logic                  soft_reset_i,
  input  logic [NUM_QPLL-1:0]   reset_req_i,
  input  logic [NUM_QPLL-1:0]   qpll_lock_i,
  input  logic [NUM_QPLL-1:0]   qpll_refclklost_i,
  output logic [NUM_QPLL-1:0]   qpll_reset_o,
  output logic [NUM_QPLL-1:0]   qpll_ready_o,
  output logic [NUM_QPLL-1:0]   qpll_fail_o,
  output logic [8*NUM_QPLL-1:0] lock_loss_cnt_o
);

  localparam int MAX_A   = (INIT_WAIT_CYC > RESET_PULSE_CYC) ? INIT_WAIT_CYC : RESET_PULSE_CYC;
  localparam int MAX_B   = (LOCK_TIMEOUT_CYC > LOCK_STABLE_CYC) ? LOCK_TIMEOUT_CYC : LOCK_STABLE_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam int RW      = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] INIT_LAST    = TW'(INIT_WAIT_CYC - 1);
  localparam logic [TW-1:0] PULSE_LAST   = TW'(RESET_PULSE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRY - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_READY,
    ST_REFCLK_WAIT,
    ST_FAIL
  } state_t;

  logic [NUM_QPLL-1:0] lock_s1, lock_s2;
  logic [NUM_QPLL-1:0] lost_s1, lost_s2;

  always_ff @(posedge sysclk_in_i or negedge reset_n) begin
    if (!reset_n) begin
      lock_s1 <= '0;
      lock_s2 <= '0;
      lost_s1 <= '0;
      lost_s2 <= '0;
    end else begin
      lock_s1 <= qpll_lock_i;
      lock_s2 <= lock_s1;
      lost_s1 <= qpll_refclklost_i;
      lost_s2 <= lost_s1;
    end
  end

  for (genvar i = 0; i < NUM_QPLL; i++) begin : g_ch
    state_t        state;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry;
    logic          rst_q, rdy_q, fail_q;
    logic          restart, lock_ok, refclk_lost;

    assign restart     = soft_reset_i | reset_req_i[i];
    assign lock_ok     = lock_s2[i];
    assign refclk_lost = lost_s2[i];

    always_ff @(posedge sysclk_in_i or negedge reset_n) begin
      if (!reset_n) begin
        state  <= ST_INIT;
        timer  <= '0;
        retry  <= '0;
        rst_q  <= 1'b1;
        rdy_q  <= 1'b0;
        fail_q <= 1'b0;
      end else if (restart) begin
        state  <= ST_INIT;
        timer  <= '0;
        retry  <= '0;
        rst_q  <= 1'b1;
        rdy_q  <= 1'b0;
        fail_q <= 1'b0;
      end else begin
        case (state)
          ST_INIT: begin
            if (timer == INIT_LAST) begin
              state <= ST_RESET;
              timer <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_RESET: begin
            if (refclk_lost) begin
              state <= ST_REFCLK_WAIT;
              timer <= '0;
            end else if (timer == PULSE_LAST) begin
              state <= ST_WAIT_LOCK;
              timer <= '0;
              rst_q <= 1'b0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (refclk_lost) begin
              state <= ST_REFCLK_WAIT;
              timer <= '0;
              rst_q <= 1'b1;
            end else if (lock_ok) begin
              state <= ST_STABLE;
              timer <= '0;
            end else if (timer == TIMEOUT_LAST) begin
              // Each timeout burns one attempt; the last one parks the channel in FAIL.
              timer <= '0;
              retry <= retry + 1'b1;
              rst_q <= 1'b1;
              if (retry == RETRY_LAST) begin
                state  <= ST_FAIL;
                fail_q <= 1'b1;
              end else begin
                state <= ST_RESET;
              end
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_STABLE: begin
            if (refclk_lost) begin
              state <= ST_REFCLK_WAIT;
              timer <= '0;
              rst_q <= 1'b1;
            end else if (!lock_ok) begin
              state <= ST_WAIT_LOCK;
              timer <= '0;
            end else if (timer == STABLE_LAST) begin
              state <= ST_READY;
              timer <= '0;
              retry <= '0;
              rdy_q <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_READY: begin
            // Refclk loss takes precedence: it explains the lock drop and is not a lock-loss event.
            if (refclk_lost) begin
              state <= ST_REFCLK_WAIT;
              timer <= '0;
              rst_q <= 1'b1;
              rdy_q <= 1'b0;
            end else if (!lock_ok) begin
              state <= ST_RESET;
              timer <= '0;
              rst_q <= 1'b1;
              rdy_q <= 1'b0;
            end
          end
          ST_REFCLK_WAIT: begin
            if (!refclk_lost) begin
              state <= ST_RESET;
              timer <= '0;
            end
          end
          ST_FAIL: begin
            rst_q  <= 1'b1;
            fail_q <= 1'b1;
          end
          default: begin
            state  <= ST_INIT;
            timer  <= '0;
            retry  <= '0;
            rst_q  <= 1'b1;
            rdy_q  <= 1'b0;
            fail_q <= 1'b0;
          end
        endcase
      end
    end

    assign qpll_reset_o[i] = rst_q;
    assign qpll_ready_o[i] = rdy_q;
    assign qpll_fail_o[i]  = fail_q;

`ifdef CPPF_QPLL_LOSS_CNT_EN
    logic       loss_evt;
    logic [7:0] loss_cnt;

    assign loss_evt = !restart && (state == ST_READY) && !refclk_lost && !lock_ok;

    always_ff @(posedge sysclk_in_i or negedge reset_n) begin
      if (!reset_n) begin
        loss_cnt <= '0;
      end else if (loss_evt && (loss_cnt != 8'hFF)) begin
        loss_cnt <= loss_cnt + 1'b1;
      end
    end

    assign lock_loss_cnt_o[8*i +: 8] = loss_cnt;
`else
    assign lock_loss_cnt_o[8*i +: 8] = 8'h00;
`endif
  end

endmodule

// File: tb/tb_cppf_qpll_reset_ctrl.sv
// Directed bench for cppf_qpll_reset_ctrl with default parameters; cycle 1 is the first edge after reset release.
module tb_cppf_qpll_reset_ctrl;
  localparam int N = 3;

`ifdef CPPF_QPLL_LOSS_CNT_EN
  localparam logic [7:0] LOSS_ONE = 8'd1;
`else
  localparam logic [7:0] LOSS_ONE = 8'd0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           soft_reset;
  logic [N-1:0]   req, lock, lost;
  logic [N-1:0]   q_rst, q_rdy, q_fail;
  logic [8*N-1:0] loss_cnt;

  int vectors = 0;
  int miscompares = 0;
  int c = 0;

  always #5 clk = ~clk;

  cppf_qpll_reset_ctrl dut (
    .sysclk_in_i       (clk),
    .reset_n           (rst_n),
    .soft_reset_i      (soft_reset),
    .reset_req_i       (req),
    .qpll_lock_i       (lock),
    .qpll_refclklost_i (lost),
    .qpll_reset_o      (q_rst),
    .qpll_ready_o      (q_rdy),
    .qpll_fail_o       (q_fail),
    .lock_loss_cnt_o   (loss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s at cycle %0d: observed=0x%0h expected=0x%0h", tag, c, obs, exp);
      $error("%s", tag);
    end
  endtask

  task automatic step_to(input int t);
    if (c < t) begin
      while (c < t) begin
        @(posedge clk);
        c++;
      end
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    soft_reset = 1'b0;
    req = '0;
    lock = '0;
    lost = '0;

    #23;
    chk("rst_reset_o", 32'(q_rst), 32'h7);
    chk("rst_ready_o", 32'(q_rdy), 32'h0);
    chk("rst_fail_o", 32'(q_fail), 32'h0);
    chk("rst_loss_cnt", 32'(loss_cnt), 32'h0);
    #5 rst_n = 1'b1;

    // Power-up: 20 INIT + 4 RESET cycles, then reset drops.
    step_to(23);
    chk("pu_reset_hi_c23", 32'(q_rst), 32'h7);
    step_to(24);
    chk("pu_reset_lo_c24", 32'(q_rst), 32'h0);

    step_to(29);
    lock = 3'b101;
    step_to(47);
    chk("pu_ready_lo_c47", 32'(q_rdy), 32'h0);
    step_to(48);
    chk("pu_ready_hi_c48", 32'(q_rdy), 32'h5);

    // Channel 2 single-cycle lock drop.
    step_to(100);
    lock[2] = 1'b0;
    step_to(101);
    lock[2] = 1'b1;
    step_to(102);
    chk("ch2_ready_still_c102", 32'(q_rdy[2]), 32'h1);
    step_to(103);
    chk("ch2_ready_drop_c103", 32'(q_rdy[2]), 32'h0);
    chk("ch2_reset_hi_c103", 32'(q_rst[2]), 32'h1);
    step_to(106);
    chk("ch2_reset_hi_c106", 32'(q_rst[2]), 32'h1);
    step_to(107);
    chk("ch2_reset_lo_c107", 32'(q_rst[2]), 32'h0);
    step_to(123);
    chk("ch2_ready_lo_c123", 32'(q_rdy[2]), 32'h0);
    step_to(124);
    chk("ch2_relock_c124", 32'(q_rdy), 32'h5);
    chk("ch2_loss_cnt", 32'(loss_cnt[23:16]), 32'(LOSS_ONE));

    // Channel 0 refclk lost for 100 cycles.
    step_to(200);
    lost[0] = 1'b1;
    step_to(202);
    chk("ch0_ready_still_c202", 32'(q_rdy[0]), 32'h1);
    step_to(203);
    chk("ch0_ready_drop_c203", 32'(q_rdy[0]), 32'h0);
    for (int t = 203; t <= 306; t++) begin
      step_to(t);
      chk("ch0_reset_held", 32'(q_rst[0]), 32'h1);
      if (t == 300) lost[0] = 1'b0;
    end
    chk("ch0_fail_lo_refclk", 32'(q_fail[0]), 32'h0);
    step_to(307);
    chk("ch0_reset_lo_c307", 32'(q_rst[0]), 32'h0);
    step_to(323);
    chk("ch0_ready_lo_c323", 32'(q_rdy[0]), 32'h0);
    step_to(324);
    chk("ch0_relock_c324", 32'(q_rdy), 32'h5);
    chk("ch0_loss_cnt_zero", 32'(loss_cnt[7:0]), 32'h0);

    // Channel 1 never locks: timeouts at 4024 and 8028, FAIL at 12032.
    step_to(4023);
    chk("ch1_reset_lo_c4023", 32'(q_rst[1]), 32'h0);
    step_to(4024);
    chk("ch1_reset_hi_c4024", 32'(q_rst[1]), 32'h1);
    chk("ch1_fail_lo_c4024", 32'(q_fail[1]), 32'h0);
    step_to(4028);
    chk("ch1_reset_lo_c4028", 32'(q_rst[1]), 32'h0);
    step_to(8028);
    chk("ch1_reset_hi_c8028", 32'(q_rst[1]), 32'h1);
    step_to(12031);
    chk("ch1_fail_lo_c12031", 32'(q_fail[1]), 32'h0);
    step_to(12032);
    chk("ch1_fail_hi_c12032", 32'(q_fail), 32'h2);
    chk("ch1_reset_hi_fail", 32'(q_rst), 32'h2);
    step_to(12040);
    req[1] = 1'b1;
    step_to(12041);
    req[1] = 1'b0;
    chk("ch1_req_fail_lo", 32'(q_fail), 32'h0);
    chk("ch1_req_reset_hi", 32'(q_rst), 32'h2);
    chk("ch1_req_others_ready", 32'(q_rdy), 32'h5);

    // Soft reset lands on the same cycle the FSMs would see a lock loss.
    step_to(12100);
    lock = 3'b000;
    step_to(12102);
    soft_reset = 1'b1;
    step_to(12103);
    soft_reset = 1'b0;
    lock = 3'b101;
    chk("sr_ready_lo", 32'(q_rdy), 32'h0);
    chk("sr_reset_hi", 32'(q_rst), 32'h7);
    chk("sr_fail_lo", 32'(q_fail), 32'h0);
    chk("sr_loss_cnt_kept", 32'(loss_cnt), 32'({LOSS_ONE, 8'h00, 8'h00}));
    step_to(12126);
    chk("sr_reset_hi_c12126", 32'(q_rst), 32'h7);
    step_to(12127);
    chk("sr_reset_lo_c12127", 32'(q_rst), 32'h0);
    step_to(12143);
    chk("sr_ready_lo_c12143", 32'(q_rdy), 32'h0);
    step_to(12144);
    chk("sr_relock_c12144", 32'(q_rdy), 32'h5);
    chk("sr_loss_cnt_final", 32'(loss_cnt), 32'({LOSS_ONE, 8'h00, 8'h00}));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
